// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, state encoding,
// operand size and the default ALU latency.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam int NDIG        = 4;
  localparam int ALU_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_N1   = 3'd0,
    ST_OPW  = 3'd1,
    ST_N2   = 3'd2,
    ST_EXEC = 3'd3,
    ST_SHOW = 3'd4
  } calc_state_e;

  // True for the four arithmetic operator keys.
  function automatic logic is_op_key(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One 4-digit BCD operand register. Digits shift in from the right, a
// counter stops entry after NDIG digits, and leading zeros are not counted.
// A clear and a digit in the same cycle give "clear, then enter the digit".
// The next-state value is exported so the display can follow it on the same
// edge.
module bcd_entry_reg
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dig_vld_i,
  input  logic [3:0]  dig_i,
  output logic [15:0] value_o,
  output logic [15:0] nxt_o
);

  localparam logic [2:0] CNT_MAX = 3'(NDIG);

  logic [15:0] value_q, value_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] base_val;
  logic [2:0]  base_cnt;

  // Next value: load wins, otherwise optional clear followed by digit entry.
  always_comb begin
    base_val = clr_i ? 16'h0000 : value_q;
    base_cnt = clr_i ? 3'd0 : cnt_q;
    value_d  = base_val;
    cnt_d    = base_cnt;
    if (load_i) begin
      value_d = load_val_i;
      cnt_d   = 3'd0;
    end else if (dig_vld_i && (base_cnt != CNT_MAX) &&
                 !((base_val == 16'h0000) && (dig_i == 4'h0))) begin
      value_d = {base_val[11:0], dig_i};
      cnt_d   = base_cnt + 3'd1;
    end
  end

  // Operand and digit-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 16'h0000;
      cnt_q   <= 3'd0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o = value_q;
  assign nxt_o   = value_d;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: turns key events into two BCD operands and an
// operator, launches the ALU, waits its fixed latency, captures the result
// and chooses what the display shows. Handshake: key_valid is a one-cycle
// strobe with no back-pressure; a key that arrives while the sequencer cannot
// use it (EXEC, or a meaningless key for the state) is dropped, never queued.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] alu_num1,
  output logic [15:0] alu_num2,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_res,
  output logic [15:0] display,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  calc_state_e state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  pend_op_q, pend_op_d;
  logic        pend_eq_q, pend_eq_d;
  logic [15:0] result_q, result_d;
  logic [15:0] display_q, display_d;
  logic [3:0]  lat_q, lat_d;

  logic        n1_clr, n1_dig, n1_load;
  logic [15:0] n1_load_val, n1_val, n1_nxt;
  logic        n2_clr, n2_dig;
  logic [15:0] n2_val, n2_nxt;
  logic        is_digit, is_op;

  assign is_digit = key_code <= 4'h9;
  assign is_op    = is_op_key(key_code);

  bcd_entry_reg u_num1 (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (n1_clr),
    .load_i     (n1_load),
    .load_val_i (n1_load_val),
    .dig_vld_i  (n1_dig),
    .dig_i      (key_code),
    .value_o    (n1_val),
    .nxt_o      (n1_nxt)
  );

  bcd_entry_reg u_num2 (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (n2_clr),
    .load_i     (1'b0),
    .load_val_i (16'h0000),
    .dig_vld_i  (n2_dig),
    .dig_i      (key_code),
    .value_o    (n2_val),
    .nxt_o      (n2_nxt)
  );

  // Next-state, operand-register control and result capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pend_op_d   = pend_op_q;
    pend_eq_d   = pend_eq_q;
    result_d    = result_q;
    lat_d       = lat_q;
    n1_clr      = 1'b0;
    n1_dig      = 1'b0;
    n1_load     = 1'b0;
    n1_load_val = result_q;
    n2_clr      = 1'b0;
    n2_dig      = 1'b0;
    if (key_valid && (key_code == KEY_CLR)) begin
      // Clear beats everything, including a completing ALU result.
      state_d   = ST_N1;
      op_d      = KEY_ADD;
      pend_op_d = KEY_ADD;
      pend_eq_d = 1'b0;
      result_d  = 16'h0000;
      lat_d     = 4'd0;
      n1_clr    = 1'b1;
      n2_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_N1: begin
          if (key_valid && is_digit) begin
            n1_dig = 1'b1;
          end else if (key_valid && is_op) begin
            op_d    = key_code;
            state_d = ST_OPW;
          end
        end
        ST_OPW: begin
          if (key_valid && is_digit) begin
            n2_clr  = 1'b1;
            n2_dig  = 1'b1;
            state_d = ST_N2;
          end else if (key_valid && is_op) begin
            op_d = key_code;
          end
        end
        ST_N2: begin
          if (key_valid && is_digit) begin
            n2_dig = 1'b1;
          end else if (key_valid && is_op) begin
            pend_op_d = key_code;
            pend_eq_d = 1'b0;
            lat_d     = 4'd0;
            state_d   = ST_EXEC;
          end else if (key_valid && (key_code == KEY_EQ)) begin
            pend_eq_d = 1'b1;
            lat_d     = 4'd0;
            state_d   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (lat_q == LAT_LAST) begin
            result_d = alu_res;
            lat_d    = 4'd0;
            if (pend_eq_q) begin
              state_d = ST_SHOW;
            end else begin
              // Chained operator: result becomes operand 1 of the next op.
              n1_load     = 1'b1;
              n1_load_val = alu_res;
              n2_clr      = 1'b1;
              op_d        = pend_op_q;
              state_d     = ST_OPW;
            end
          end else begin
            lat_d = lat_q + 4'd1;
          end
        end
        ST_SHOW: begin
          if (key_valid && is_op) begin
            n1_load = 1'b1;
            op_d    = key_code;
            state_d = ST_OPW;
          end else if (key_valid && (key_code == KEY_EQ)) begin
            // Repeat-equals: previous result with the same op and operand 2.
            n1_load   = 1'b1;
            pend_eq_d = 1'b1;
            lat_d     = 4'd0;
            state_d   = ST_EXEC;
          end
        end
        default: state_d = ST_N1;
      endcase
    end
  end

  // Display follows the source selected by the next state, on the same edge.
  always_comb begin
    case (state_d)
      ST_N1, ST_OPW: display_d = n1_nxt;
      ST_N2:         display_d = n2_nxt;
      ST_SHOW:       display_d = result_d;
      default:       display_d = display_q;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_N1;
      op_q      <= KEY_ADD;
      pend_op_q <= KEY_ADD;
      pend_eq_q <= 1'b0;
      result_q  <= 16'h0000;
      display_q <= 16'h0000;
      lat_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pend_op_q <= pend_op_d;
      pend_eq_q <= pend_eq_d;
      result_q  <= result_d;
      display_q <= display_d;
      lat_q     <= lat_d;
    end
  end

  assign alu_num1  = n1_val;
  assign alu_num2  = n2_val;
  assign alu_op    = op_q;
  assign display   = display_q;
  assign busy      = (state_q == ST_EXEC);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with hand-computed expectations.
module tb_calc_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [3:0]  alu_op;
  logic [15:0] alu_res;
  logic [15:0] display;
  logic        busy;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int n_busy;

  calc_seq_ctrl #(.ALU_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .alu_num1  (alu_num1),
    .alu_num2  (alu_num2),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .display   (display),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; key is sampled on the following posedge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Counts busy cycles at negedges, bounded so a stuck EXEC still ends.
  task automatic wait_exec(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    alu_res   = 16'h0000;
    #12;
    chk("rst_num1", alu_num1, 16'h0000);
    chk("rst_num2", alu_num2, 16'h0000);
    chk("rst_op", {12'h0, alu_op}, 16'h000A);
    chk("rst_disp", display, 16'h0000);
    chk("rst_busy", {15'h0, busy}, 16'h0000);
    chk("rst_state", {13'h0, state_dbg}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1 2 + 3 4 =
    alu_res = 16'h0046;
    press(4'h1); chk("t1_disp1", display, 16'h0001);
    press(4'h2); chk("t1_disp12", display, 16'h0012);
    press(4'hA); chk("t1_opw", {13'h0, state_dbg}, 16'h0001);
    chk("t1_disp_opw", display, 16'h0012);
    press(4'h3); chk("t1_n2", {13'h0, state_dbg}, 16'h0002);
    chk("t1_disp3", display, 16'h0003);
    press(4'h4); chk("t1_disp34", display, 16'h0034);
    press(4'hE);
    chk("t1_busy", {15'h0, busy}, 16'h0001);
    chk("t1_num1", alu_num1, 16'h0012);
    chk("t1_num2", alu_num2, 16'h0034);
    chk("t1_op", {12'h0, alu_op}, 16'h000A);
    chk("t1_disp_hold", display, 16'h0034);
    wait_exec(n_busy);
    chk("t1_busy_cycles", 16'(n_busy), 16'd2);
    chk("t1_show", {13'h0, state_dbg}, 16'h0004);
    chk("t1_res", display, 16'h0046);

    // repeat equals
    alu_res = 16'h0080;
    press(4'hE);
    chk("t4_num1", alu_num1, 16'h0046);
    chk("t4_num2", alu_num2, 16'h0034);
    chk("t4_op", {12'h0, alu_op}, 16'h000A);
    wait_exec(n_busy);
    chk("t4_busy_cycles", 16'(n_busy), 16'd2);
    chk("t4_disp", display, 16'h0080);
    chk("t4_show", {13'h0, state_dbg}, 16'h0004);

    // digit limit and leading-zero suppression
    press(4'hF);
    chk("t2_clr_state", {13'h0, state_dbg}, 16'h0000);
    chk("t2_clr_disp", display, 16'h0000);
    chk("t2_clr_op", {12'h0, alu_op}, 16'h000A);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("t2_num1_1234", alu_num1, 16'h1234);
    chk("t2_disp_1234", display, 16'h1234);
    press(4'hF);
    press(4'h0); press(4'h0);
    chk("t2_zeros", alu_num1, 16'h0000);
    press(4'h7);
    chk("t2_num1_7", alu_num1, 16'h0007);
    press(4'h1); press(4'h2); press(4'h3);
    chk("t2_num1_7123", alu_num1, 16'h7123);
    press(4'h4);
    chk("t2_count_full", alu_num1, 16'h7123);
    press(4'hE);
    chk("t2_eq_ignored", {13'h0, state_dbg}, 16'h0000);

    // chained operation 5 + 3 - 2 =
    press(4'hF);
    alu_res = 16'h0008;
    press(4'h5); press(4'hA); press(4'h3); press(4'hB);
    chk("t3_busy", {15'h0, busy}, 16'h0001);
    chk("t3_l1_num1", alu_num1, 16'h0005);
    chk("t3_l1_num2", alu_num2, 16'h0003);
    chk("t3_l1_op", {12'h0, alu_op}, 16'h000A);
    wait_exec(n_busy);
    chk("t3_l1_cycles", 16'(n_busy), 16'd2);
    chk("t3_opw", {13'h0, state_dbg}, 16'h0001);
    chk("t3_num1_res", alu_num1, 16'h0008);
    chk("t3_num2_clr", alu_num2, 16'h0000);
    chk("t3_pend_op", {12'h0, alu_op}, 16'h000B);
    chk("t3_disp_mid", display, 16'h0008);
    alu_res = 16'h0006;
    press(4'h2);
    chk("t3_disp2", display, 16'h0002);
    press(4'hE);
    chk("t3_l2_num1", alu_num1, 16'h0008);
    chk("t3_l2_num2", alu_num2, 16'h0002);
    chk("t3_l2_op", {12'h0, alu_op}, 16'h000B);
    wait_exec(n_busy);
    chk("t3_disp_end", display, 16'h0006);
    chk("t3_show", {13'h0, state_dbg}, 16'h0004);

    // clear on the first busy cycle
    press(4'hF);
    alu_res = 16'h0099;
    press(4'h1); press(4'hA); press(4'h2); press(4'hE);
    chk("t5_busy_before", {15'h0, busy}, 16'h0001);
    press(4'hF);
    chk("t5_busy", {15'h0, busy}, 16'h0000);
    chk("t5_state", {13'h0, state_dbg}, 16'h0000);
    chk("t5_disp", display, 16'h0000);
    repeat (4) @(negedge clk);
    chk("t5_disp_late", display, 16'h0000);
    chk("t5_state_late", {13'h0, state_dbg}, 16'h0000);
    chk("t5_num1_late", alu_num1, 16'h0000);

    // digit during EXEC is dropped
    alu_res = 16'h0003;
    press(4'h1); press(4'hA); press(4'h2); press(4'hE);
    press(4'h9);
    chk("t6_exec_busy", {15'h0, busy}, 16'h0001);
    chk("t6_num2_kept", alu_num2, 16'h0002);
    chk("t6_disp_hold", display, 16'h0002);
    wait_exec(n_busy);
    chk("t6_show", {13'h0, state_dbg}, 16'h0004);
    chk("t6_res", display, 16'h0003);

    // asynchronous reset mid-entry
    press(4'hF);
    press(4'h1); press(4'h2); press(4'h3);
    chk("t6_num1_123", alu_num1, 16'h0123);
    press(4'hC);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ar_num1", alu_num1, 16'h0000);
    chk("t6_ar_op", {12'h0, alu_op}, 16'h000A);
    chk("t6_ar_disp", display, 16'h0000);
    chk("t6_ar_state", {13'h0, state_dbg}, 16'h0000);
    chk("t6_ar_busy", {15'h0, busy}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press(4'h4);
    chk("t6_after_rst", alu_num1, 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
